// File: rtl/rstatus_queue_pkg.sv
// rstatus_queue_pkg -- shared status-code definitions for the exception-status queue.
//   Source i on the ovf_valid bus reports status code i+1. The default source order
//   is add, addi, sub, mult, div. Code 0 means "no status".
package rstatus_queue_pkg;

   // Status codes written to $rstatus
   localparam int RSTAT_NONE = 0;
   localparam int RSTAT_ADD  = 1;
   localparam int RSTAT_ADDI = 2;
   localparam int RSTAT_SUB  = 3;
   localparam int RSTAT_MULT = 4;
   localparam int RSTAT_DIV  = 5;

   // Source-index order on the ovf_valid bus
   localparam int SRC_ADD  = 0;
   localparam int SRC_ADDI = 1;
   localparam int SRC_SUB  = 2;
   localparam int SRC_MULT = 3;
   localparam int SRC_DIV  = 4;

   // Status code reported by overflow source number src
   function automatic int code_of_src(input int src);
      return src + 1;
   endfunction

endpackage

// File: rtl/rstatus_queue_if.sv
// rstatus_queue_if -- writeback handshake between the status queue and the
// register-file port that updates $rstatus.
//   wb_req  : a status word is available (driven by master)
//   wb_data : status word, zero-extended code (driven by master)
//   wb_ack  : writeback port accepts wb_data this cycle (driven by slave)
interface rstatus_queue_if #(
   parameter int DATA_W = 32
);
   logic              wb_req;
   logic [DATA_W-1:0] wb_data;
   logic              wb_ack;

   modport master (output wb_req, output wb_data, input wb_ack);
   modport slave  (input wb_req, input wb_data, output wb_ack);
endinterface

// File: rtl/rstatus_queue_status_fifo.sv
// status_fifo -- generic synchronous FIFO with a combinational head view.
//   clock, reset_n : clock and asynchronous active-low reset
//   push, wr_data  : write request and data; accepted when not full or when
//                    a pop happens in the same cycle
//   pop            : remove head; ignored when empty
//   flush          : clear all entries, overrides push and pop
//   head           : oldest entry (valid while count != 0)
//   count, full    : occupancy and count == DEPTH
module status_fifo #(
   parameter int WIDTH = 3,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_pop;
   logic             do_push;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign count   = count_reg;
   assign do_pop  = pop & (count_reg != '0) & ~flush;
   // A pop frees the slot the push needs, so a full queue still accepts
   assign do_push = push & (~full | do_pop) & ~flush;

   // Small array read asynchronously so a pushed entry is visible right after its edge
   assign head = mem[rd_ptr_reg];

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (do_push && !do_pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (do_pop && !do_push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

endmodule

// File: rtl/rstatus_queue.sv
// rstatus_queue -- exception-status unit: priority-encodes overflow events into
// status codes, queues them and drains one per writeback handshake.
//   clock, reset_n : clock and asynchronous active-low reset
//   ovf_valid      : one overflow bit per source; lowest set index wins
//   flush          : clear queued entries; discards this cycle's push and ack
//   wb             : writeback handshake (wb_req / wb_data / wb_ack)
//   last_code      : last code accepted by writeback, zero-extended
//   pending, full  : queue occupancy and occupancy == DEPTH
//   drop_cnt, lost : saturating count of events lost to a full queue, sticky flag
module rstatus_queue
   import rstatus_queue_pkg::*;
#(
   parameter int NUM_SRC = 5,
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 32,
   parameter int DROP_W  = 8
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [NUM_SRC-1:0]         ovf_valid,
   input  logic                       flush,
   rstatus_queue_if.master            wb,
   output logic [DATA_W-1:0]          last_code,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       full,
   output logic [DROP_W-1:0]          drop_cnt,
   output logic                       lost
);
   localparam int CODE_W = $clog2(NUM_SRC+1);

   logic [CODE_W-1:0] enc_code;
   logic [CODE_W-1:0] head;
   logic [CODE_W-1:0] last_code_reg;
   logic [DROP_W-1:0] drop_cnt_reg;
   logic              lost_reg;
   logic              push_req;
   logic              pop;
   logic              drop;
   logic              fifo_full;
   logic              have_entry;

   // Scan from the top so the lowest set index is the final assignment
   always_comb begin
      enc_code = '0;
      for (int i = NUM_SRC-1; i >= 0; i--) begin
         if (ovf_valid[i]) begin
            enc_code = CODE_W'(code_of_src(i));
         end
      end
   end

   assign have_entry = (pending != '0);
   assign push_req   = (|ovf_valid) & ~flush;
   assign pop        = have_entry & wb.wb_ack & ~flush;
   assign drop       = push_req & fifo_full & ~pop;

   status_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push_req),
      .wr_data (enc_code),
      .pop     (pop),
      .flush   (flush),
      .head    (head),
      .count   (pending),
      .full    (fifo_full)
   );

   assign full       = fifo_full;
   assign wb.wb_req  = have_entry;
   assign wb.wb_data = have_entry ? DATA_W'(head) : '0;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_code_reg <= '0;
         drop_cnt_reg  <= '0;
         lost_reg      <= 1'b0;
      end else begin
         if (pop) begin
            last_code_reg <= head;
         end
         if (drop) begin
            lost_reg <= 1'b1;
            if (drop_cnt_reg != '1) begin
               drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
         end
      end
   end

   assign last_code = DATA_W'(last_code_reg);
   assign drop_cnt  = drop_cnt_reg;
   assign lost      = lost_reg;

endmodule

// File: tb/tb_rstatus_queue.sv
// tb_rstatus_queue -- randomized and directed bench for rstatus_queue against a
// queue-based reference model.
module tb_rstatus_queue;
   import rstatus_queue_pkg::*;

   localparam int NUM_SRC = 5;
   localparam int DEPTH   = 4;
   localparam int DATA_W  = 32;
   localparam int DROP_W  = 8;
   localparam int PEND_W  = $clog2(DEPTH+1);
   localparam int DROP_MAX = (1 << DROP_W) - 1;

   logic                clock;
   logic                reset_n;
   logic [NUM_SRC-1:0]  ovf_valid;
   logic                flush;
   logic [DATA_W-1:0]   last_code;
   logic [PEND_W-1:0]   pending;
   logic                full;
   logic [DROP_W-1:0]   drop_cnt;
   logic                lost;

   rstatus_queue_if #(.DATA_W(DATA_W)) wb_if_i ();

   rstatus_queue #(
      .NUM_SRC (NUM_SRC),
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .DROP_W  (DROP_W)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .ovf_valid (ovf_valid),
      .flush     (flush),
      .wb        (wb_if_i),
      .last_code (last_code),
      .pending   (pending),
      .full      (full),
      .drop_cnt  (drop_cnt),
      .lost      (lost)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model state
   int m_q[$];
   int m_last;
   int m_drops;
   bit m_lost;

   int n_checks;
   int n_errors;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_last  = 0;
      m_drops = 0;
      m_lost  = 0;
   endtask

   // Apply one cycle's inputs to the model: flush wins, then pop, then push
   task automatic model_step(input logic [NUM_SRC-1:0] ovf, input logic fl, input logic ack);
      int code;
      if (fl) begin
         m_q.delete();
         return;
      end
      if (m_q.size() > 0 && ack) begin
         m_last = m_q.pop_front();
      end
      if (ovf != '0) begin
         code = 0;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (ovf[i] && code == 0) code = i + 1;
         end
         if (m_q.size() < DEPTH) begin
            m_q.push_back(code);
         end else begin
            m_lost = 1;
            if (m_drops < DROP_MAX) m_drops++;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check_eq({tag, ".wb_req"},    32'(wb_if_i.wb_req), 32'(m_q.size() != 0));
      check_eq({tag, ".wb_data"},   wb_if_i.wb_data, (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
      check_eq({tag, ".pending"},   32'(pending),   32'(m_q.size()));
      check_eq({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
      check_eq({tag, ".last_code"}, last_code,      32'(m_last));
      check_eq({tag, ".drop_cnt"},  32'(drop_cnt),  32'(m_drops));
      check_eq({tag, ".lost"},      32'(lost),      32'(m_lost));
   endtask

   // Drive inputs, clock once, then compare just after the edge
   task automatic cycle(input string tag, input logic [NUM_SRC-1:0] ovf,
                        input logic fl, input logic ack);
      ovf_valid      = ovf;
      flush          = fl;
      wb_if_i.wb_ack = ack;
      model_step(ovf, fl, ack);
      @(posedge clock);
      #1;
      compare_all(tag);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      reset_n = 1'b0;
      ovf_valid = '0;
      flush = 1'b0;
      wb_if_i.wb_ack = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      compare_all("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // Single event, then ack
      cycle("single_push", 5'b00001, 1'b0, 1'b0);
      check_eq("single_push.data_is_add", wb_if_i.wb_data, 32'(RSTAT_ADD));
      cycle("single_ack", 5'b00000, 1'b0, 1'b1);
      check_eq("single_ack.last_add", last_code, 32'(RSTAT_ADD));

      // Multiple sources: lowest index wins, no drop
      cycle("prio", 5'b10100, 1'b0, 1'b0);
      check_eq("prio.code_sub", wb_if_i.wb_data, 32'(RSTAT_SUB));
      cycle("prio_drain", 5'b00000, 1'b0, 1'b1);

      // Overfill with ack held low: codes 1..5 then 1
      for (int k = 0; k < 6; k++) begin
         cycle($sformatf("fill%0d", k), 5'(1 << (k % 5)), 1'b0, 1'b0);
      end
      check_eq("fill.drops", 32'(drop_cnt), 32'd2);

      // Push code 5 and ack on a full queue
      cycle("full_push_ack", 5'b10000, 1'b0, 1'b1);
      check_eq("full_push_ack.pending", 32'(pending), 32'(DEPTH));
      for (int k = 0; k < DEPTH; k++) begin
         cycle($sformatf("drain%0d", k), 5'b00000, 1'b0, 1'b1);
      end
      check_eq("drain.last_div", last_code, 32'(RSTAT_DIV));

      // Three entries then flush with push and ack in the same cycle
      for (int k = 0; k < 3; k++) begin
         cycle($sformatf("pre_flush%0d", k), 5'(1 << k), 1'b0, 1'b0);
      end
      cycle("flush", 5'b00010, 1'b1, 1'b1);

      // Saturating drop counter
      for (int k = 0; k < DEPTH + DROP_MAX + 4; k++) begin
         cycle("sat", 5'b01000, 1'b0, 1'b0);
      end
      check_eq("sat.drop_cnt", 32'(drop_cnt), 32'(DROP_MAX));
      cycle("sat_flush", 5'b00000, 1'b1, 1'b0);

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         logic [NUM_SRC-1:0] r_ovf;
         logic r_fl;
         logic r_ack;
         r_ovf = ($urandom_range(0, 2) == 0) ? '0 : NUM_SRC'($urandom);
         r_fl  = ($urandom_range(0, 19) == 0);
         r_ack = ($urandom_range(0, 2) != 0);
         cycle("rand", r_ovf, r_fl, r_ack);
      end

      // Asynchronous reset mid-drain
      cycle("pre_rst_flush", 5'b00000, 1'b1, 1'b0);
      cycle("pre_rst_a", 5'b00100, 1'b0, 1'b0);
      cycle("pre_rst_b", 5'b00010, 1'b0, 1'b0);
      cycle("pre_rst_c", 5'b00000, 1'b0, 1'b1);
      cycle("pre_rst_d", 5'b00001, 1'b0, 1'b0);
      check_eq("pre_rst.pending", 32'(pending), 32'd2);
      ovf_valid = '0;
      wb_if_i.wb_ack = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all("async_rst");
      @(negedge clock);
      reset_n = 1'b1;
      cycle("post_rst", 5'b00000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
